axis_check_arbiter: RTL and testbench



---
 rtl/axis_check_arbiter.sv | 127 ++++++++++++
 tb/tb_axis_check_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/axis_check_arbiter.sv
// Round-robin AXIS arbiter: grants one source per fixed burst and forwards beats through a registered output slot tagged with the source port.
// Optional trace build: define ARB_TRACE_EN to get grant messages and starvation warnings.
module axis_check_arbiter #(
  parameter int DATA_WIDTH = 10,
  parameter int NUM_PORTS  = 4,
  parameter int BURST      = 1,
  localparam int PORT_W    = $clog2(NUM_PORTS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            in_valid,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
  output logic [NUM_PORTS-1:0]            in_ready,
  output logic                            out_valid,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [PORT_W-1:0]               out_port,
  input  logic                            out_ready,
  output logic                            busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] LAST_BEAT = 8'(BURST - 1);

  state_t              state;
  logic [PORT_W-1:0]   gnt;
  logic [PORT_W-1:0]   last;
  logic [PORT_W-1:0]   next_port;
  logic [7:0]          cnt;
  logic                accept;
  logic [DATA_WIDTH-1:0] gnt_data;

  // Search from last+1 upward; iterating the offsets downward lets the nearest requester win.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    next_port = last;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      if (in_valid[PORT_W'((int'(last) + k) % NUM_PORTS)])
        next_port = PORT_W'((int'(last) + k) % NUM_PORTS);
    end
  end

  // Ready depends on out_ready and registered state only, never on in_valid.
  always_comb begin
    in_ready = '0;
    if (state == GRANT)
      in_ready[gnt] = !out_valid || out_ready;
  end

  assign accept   = (state == GRANT) && in_valid[gnt] && in_ready[gnt];
  assign gnt_data = in_data[gnt*DATA_WIDTH +: DATA_WIDTH];
  assign busy     = (state == GRANT);

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      cnt       <= '0;
      last      <= PORT_W'(NUM_PORTS - 1);
      out_valid <= 1'b0;
      out_data  <= '0;
      out_port  <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= gnt_data;
        out_port  <= gnt;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (|in_valid) begin
            gnt   <= next_port;
            cnt   <= '0;
            state <= GRANT;
          end
        end
        GRANT: begin
          // The grant is held across idle source cycles; only accepted beats advance the count.
          if (accept) begin
            cnt <= cnt + 8'd1;
            if (cnt == LAST_BEAT) begin
              last  <= gnt;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_TRACE_EN
  localparam int STARVE_LIMIT = NUM_PORTS * (BURST + 1) + 4;

  int unsigned          wait_cnt [NUM_PORTS];
  logic [NUM_PORTS-1:0] starve_flag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PORTS; i++) wait_cnt[i] <= 0;
      starve_flag <= '0;
    end else begin
      if (state == IDLE && |in_valid)
        $info("Grant port %0d", next_port);
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (!in_valid[i] || (state == GRANT && gnt == PORT_W'(i))) begin
          wait_cnt[i]    <= 0;
          starve_flag[i] <= 1'b0;
        end else begin
          if (wait_cnt[i] != 32'hFFFF_FFFF)
            wait_cnt[i] <= wait_cnt[i] + 1;
          // One report per wait episode; the flag clears when the episode ends.
          if (wait_cnt[i] >= STARVE_LIMIT && !starve_flag[i]) begin
            $display("Starvation port %0d", i);
            starve_flag[i] <= 1'b1;
          end
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_axis_check_arbiter.sv
// Randomized bench for axis_check_arbiter against a transaction-style reference model
// (remaining-beats countdown, per-port producers with sequence counters).
module tb_axis_check_arbiter;

  localparam int DW    = 10;
  localparam int NP    = 4;
  localparam int BURST = 3;
  localparam int PW    = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [NP-1:0]      in_valid;
  logic [NP*DW-1:0]   in_data;
  logic [NP-1:0]      in_ready;
  logic               out_valid;
  logic [DW-1:0]      out_data;
  logic [PW-1:0]      out_port;
  logic               out_ready;
  logic               busy;

  axis_check_arbiter #(.DATA_WIDTH(DW), .NUM_PORTS(NP), .BURST(BURST)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_port  (out_port),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: who owns the consumer, how many beats remain, and what sits in the slot.
  int          m_busy, m_port, m_left, m_last, m_ov, m_op;
  logic [DW-1:0] m_od;
  int          seq [NP];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] port_data(input int i);
    return DW'(16 * i + seq[i]);
  endfunction

  function automatic logic [NP-1:0] exp_ready();
    logic [NP-1:0] r;
    r = '0;
    if (m_busy != 0 && (m_ov == 0 || out_ready)) r[m_port] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_port = 0; m_left = 0; m_last = NP - 1;
    m_ov = 0; m_od = '0; m_op = 0;
  endtask

  task automatic model_edge();
    int was_busy;
    logic [NP-1:0] rdy;
    was_busy = m_busy;
    rdy = exp_ready();
    if (was_busy != 0 && in_valid[m_port] && rdy[m_port]) begin
      m_ov = 1;
      m_od = port_data(m_port);
      m_op = m_port;
      seq[m_port]++;
      m_left--;
      if (m_left == 0) begin
        m_busy = 0;
        m_last = m_port;
      end
    end else if (out_ready) begin
      m_ov = 0;
    end
    if (was_busy == 0 && in_valid != '0) begin
      for (int k = 1; k <= NP; k++) begin
        if (in_valid[(m_last + k) % NP]) begin
          m_port = (m_last + k) % NP;
          break;
        end
      end
      m_busy = 1;
      m_left = BURST;
    end
  endtask

  task automatic drive(input logic [NP-1:0] v, input logic r);
    in_valid  = v;
    out_ready = r;
    for (int i = 0; i < NP; i++) in_data[i*DW +: DW] = port_data(i);
  endtask

  task automatic compare_all();
    check("in_ready",  32'(in_ready),  32'(exp_ready()));
    check("out_valid", 32'(out_valid), 32'(m_ov));
    check("out_data",  32'(out_data),  32'(m_od));
    check("out_port",  32'(out_port),  32'(m_op));
    check("busy",      32'(busy),      32'(m_busy));
  endtask

  // One clock: drive at the falling edge, compare just after, advance the model at the rising edge.
  task automatic cycle(input logic [NP-1:0] v, input logic r);
    drive(v, r);
    #1 compare_all();
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NP-1:0] v;
    int drop;
    bit found;

    for (int i = 0; i < NP; i++) seq[i] = 0;
    model_reset();
    rst = 1'b1;
    drive('1, 1'b1);
    @(negedge clk);

    // Reset held three cycles with every source requesting.
    repeat (3) cycle('1, 1'b1);
    rst = 1'b0;
    cycle('1, 1'b1);
    drive('1, 1'b1);
    #1 check("first_grant_p0", 32'(in_ready), 32'h1);
    cycle('1, 1'b1);

    // Round robin with all ports busy.
    repeat (40) cycle('1, 1'b1);

    // Burst lock: ports 1 and 2, port 1 pauses for two cycles after its first beat.
    drop = 0;
    for (int c = 0; c < 40; c++) begin
      v = 4'b0110;
      if (m_busy != 0 && m_port == 1 && m_left == BURST - 1 && drop < 2) begin
        v[1] = 1'b0;
        drop++;
      end
      cycle(v, 1'b1);
    end
    check("burst_lock_pause_seen", 32'(drop), 32'd2);

    // Backpressure: stall five cycles once the slot is full.
    found = 0;
    for (int c = 0; c < 20; c++) begin
      if (m_ov != 0) begin found = 1; break; end
      cycle('1, 1'b1);
    end
    check("bp_slot_filled", 32'(found), 32'd1);
    repeat (5) cycle('1, 1'b0);
    repeat (10) cycle('1, 1'b1);

    // Sparse: only port 3 requests.
    repeat (24) cycle(4'b1000, 1'b1);

    // Random traffic and random backpressure.
    for (int c = 0; c < 1500; c++) begin
      v = NP'($urandom);
      cycle(v, ($urandom_range(0, 3) != 0));
    end

    // Mid-burst reset: strike while the second beat of a burst is pending.
    found = 0;
    for (int c = 0; c < 60; c++) begin
      if (m_busy != 0 && m_left == BURST - 1 && m_ov != 0) begin found = 1; break; end
      cycle('1, 1'b1);
    end
    check("mid_burst_reached", 32'(found), 32'd1);
    drive('1, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_in_ready",  32'(in_ready),  32'd0);
    check("async_rst_busy",      32'(busy),      32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cycle('1, 1'b1);
    drive('1, 1'b1);
    #1 check("restart_grant_p0", 32'(in_ready), 32'h1);
    repeat (20) cycle('1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
